// File: rtl/dff_sweep_pkg.sv
// Shared types and constants for the two-flop timing sweep controller.
package dff_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CLK_HI,
    CLK_LO,
    SEL,
    SAMPLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [1:0] SEL_D   = 2'd0;
  localparam logic [1:0] SEL_CLK = 2'd1;
  localparam logic [1:0] SEL_Q0  = 2'd2;
  localparam logic [1:0] SEL_Q1  = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dff_sweep_ctrl_if.sv
// Bus between the sweep controller and the two-flop DUT: stimulus out, mux line back.
interface dff_sweep_ctrl_if;
  import dff_sweep_pkg::*;

  logic       o_d;
  logic       o_dut_clk;
  logic [1:0] o_sel;
  logic       i_mux;

  modport master (output o_d, output o_dut_clk, output o_sel, input i_mux);
  modport slave  (input  o_d, input  o_dut_clk, input  o_sel, output i_mux);

endinterface

// File: rtl/dff_sweep_ctrl_sync_2ff.sv
// Two-flop synchroniser for the asynchronous DUT observation line.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dff_sweep_ctrl.sv
// Drives data/clock to the two-flop DUT with a programmable offset, then reads
// back d/clk/q0/q1 through the 4:1 mux and counts capture errors per flop.
module dff_sweep_ctrl
  import dff_sweep_pkg::*;
#(
  parameter int N_TRIAL = 16,
  parameter int HI_CYC  = 4,
  parameter int SETTLE  = 8,
  parameter int CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [3:0]        i_offset,
  dff_sweep_ctrl_if.master  dut,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_err0,
  output logic [CNT_W-1:0]  o_err1,
  output logic              o_clk_err,
  output logic [3:0]        o_sample
);

  // One down-counter serves every timed state; size it for the longest wait.
  localparam int CW = $clog2(max3(16, HI_CYC, SETTLE));
  localparam int TW = (N_TRIAL > 1) ? $clog2(N_TRIAL) : 1;
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [TW-1:0]    r_trial;
  logic [3:0]       r_off;
  logic             r_d;
  logic             r_dut_clk;
  logic [1:0]       r_sel;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_err0;
  logic [CNT_W-1:0] r_err1;
  logic             r_clk_err;
  logic [3:0]       r_sample;
  logic             w_mux_sync;

  sync_2ff u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (dut.i_mux),
    .o_q   (w_mux_sync)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_trial   <= '0;
      r_off     <= '0;
      r_d       <= 1'b0;
      r_dut_clk <= 1'b0;
      r_sel     <= SEL_D;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err0    <= '0;
      r_err1    <= '0;
      r_clk_err <= 1'b0;
      r_sample  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state   <= DRIVE;
            r_off     <= i_offset;
            r_cnt     <= CW'(i_offset);
            r_d       <= ~r_d;
            r_busy    <= 1'b1;
            r_err0    <= '0;
            r_err1    <= '0;
            r_clk_err <= 1'b0;
            r_trial   <= '0;
          end
        end
        DRIVE: begin
          if (r_cnt == '0) begin
            r_state   <= CLK_HI;
            r_dut_clk <= 1'b1;
            r_cnt     <= CW'(HI_CYC - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CLK_HI: begin
          if (r_cnt == '0) begin
            r_state   <= CLK_LO;
            r_dut_clk <= 1'b0;
            r_cnt     <= CW'(HI_CYC - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CLK_LO: begin
          if (r_cnt == '0) begin
            r_state <= SEL;
            r_sel   <= SEL_D;
            r_cnt   <= CW'(SETTLE - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        SEL: begin
          if (r_cnt == '0) r_state <= SAMPLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        SAMPLE: begin
          r_sample[r_sel] <= w_mux_sync;
          if (r_sel != SEL_Q1) begin
            r_state <= SEL;
            r_sel   <= r_sel + 1'b1;
            r_cnt   <= CW'(SETTLE - 1);
          end else begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (r_sample[SEL_Q0] != r_sample[SEL_D] && r_err0 != ERR_MAX)
            r_err0 <= r_err0 + 1'b1;
          if (r_sample[SEL_Q1] != r_sample[SEL_D] && r_err1 != ERR_MAX)
            r_err1 <= r_err1 + 1'b1;
          if (r_sample[SEL_CLK])
            r_clk_err <= 1'b1;
          if (r_trial == TW'(N_TRIAL - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= DRIVE;
            r_trial <= r_trial + 1'b1;
            r_d     <= ~r_d;
            r_cnt   <= CW'(r_off);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dut.o_d       = r_d;
  assign dut.o_dut_clk = r_dut_clk;
  assign dut.o_sel     = r_sel;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err0        = r_err0;
  assign o_err1        = r_err1;
  assign o_clk_err     = r_clk_err;
  assign o_sample      = r_sample;

endmodule

// File: tb/tb_dff_sweep_ctrl.sv
// Directed bench: a behavioural two-flop DUT with injectable faults sits behind
// each controller instance (u_dut: CNT_W=8, u_sat: CNT_W=3).
`timescale 1ns/1ps
module tb_dff_sweep_ctrl;
  import dff_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_a, start_b;
  logic [3:0] off_a, off_b;
  logic       busy_a, done_a, clk_err_a, busy_b, done_b, clk_err_b;
  logic [7:0] err0_a, err1_a;
  logic [2:0] err0_b, err1_b;
  logic [3:0] smp_a, smp_b;

  dff_sweep_ctrl_if ifa ();
  dff_sweep_ctrl_if ifb ();

  dff_sweep_ctrl #(.N_TRIAL(16), .HI_CYC(4), .SETTLE(8), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_offset(off_a), .dut(ifa),
    .o_busy(busy_a), .o_done(done_a), .o_err0(err0_a), .o_err1(err1_a),
    .o_clk_err(clk_err_a), .o_sample(smp_a)
  );

  dff_sweep_ctrl #(.N_TRIAL(16), .HI_CYC(4), .SETTLE(8), .CNT_W(3)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_offset(off_b), .dut(ifb),
    .o_busy(busy_b), .o_done(done_b), .o_err0(err0_b), .o_err1(err1_b),
    .o_clk_err(clk_err_b), .o_sample(smp_b)
  );

  // Behavioural two-flop DUTs; a setup violation makes q1 capture the previous data.
  bit   viol_a = 1'b0, clk_stuck_a = 1'b0, q0_stuck_b = 1'b0;
  int   cur_off_a = 0;
  logic q0a = 1'b0, q1a = 1'b0, q0b = 1'b0, q1b = 1'b0;

  always @(posedge ifa.o_dut_clk) begin
    q0a <= ifa.o_d;
    q1a <= (viol_a && cur_off_a < 2) ? ~ifa.o_d : ifa.o_d;
  end
  always @(posedge ifb.o_dut_clk) begin
    q0b <= q0_stuck_b ? 1'b0 : ifb.o_d;
    q1b <= ifb.o_d;
  end

  assign ifa.i_mux = (ifa.o_sel == SEL_D)   ? ifa.o_d :
                     (ifa.o_sel == SEL_CLK) ? (ifa.o_dut_clk | clk_stuck_a) :
                     (ifa.o_sel == SEL_Q0)  ? q0a : q1a;
  assign ifb.i_mux = (ifb.o_sel == SEL_D)   ? ifb.o_d :
                     (ifb.o_sel == SEL_CLK) ? ifb.o_dut_clk :
                     (ifb.o_sel == SEL_Q0)  ? q0b : q1b;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the first cycle after the start edge.
  task automatic go(input int which, input logic [3:0] off);
    @(negedge clk);
    if (which == 0) begin off_a = off; cur_off_a = int'(off); start_a = 1'b1; end
    else            begin off_b = off; start_b = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // n counts cycles since the start edge; a timeout returns the limit.
  task automatic wait_done(input int which, input int n0, input int limit, output int n);
    n = n0;
    while (!((which == 0) ? done_a : done_b) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [31:0] all_a();
    return 32'({busy_a, done_a, ifa.o_d, ifa.o_dut_clk, ifa.o_sel, err0_a, err1_a, clk_err_a, smp_a});
  endfunction
  function automatic logic [31:0] all_b();
    return 32'({busy_b, done_b, ifb.o_d, ifb.o_dut_clk, ifb.o_sel, err0_b, err1_b, clk_err_b, smp_b});
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nd;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; off_a = '0; off_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_a", all_a(), 32'd0);
    chk("reset_b", all_b(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean loopback, offset 3: 49-cycle trials.
    go(0, 4'd3);
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_dtog", 32'(ifa.o_d), 32'd1);
    n = 1;
    while (!ifa.o_dut_clk && n < 50) begin @(negedge clk); n++; end
    chk("t1_clk_rise", 32'(n), 32'd5);
    wait_done(0, n, 2000, n);
    chk("t1_len", 32'(n), 32'd785);
    chk("t1_busy_fall", 32'(busy_a), 32'd0);
    chk("t1_errs", 32'({err0_a, err1_a, clk_err_a}), 32'd0);
    chk("t1_d_end", 32'(ifa.o_d), 32'd0);
    chk("t1_sample", 32'(smp_a), 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done_a), 32'd0);

    // Setup violation on flop 1 at offset 0.
    viol_a = 1'b1;
    go(0, 4'd0);
    wait_done(0, 1, 2000, n);
    chk("t2_len", 32'(n), 32'd737);
    chk("t2_err1", 32'(err1_a), 32'd16);
    chk("t2_err0", 32'(err0_a), 32'd0);
    viol_a = 1'b0;

    // q0 stuck low on the CNT_W=3 instance: 8 real mismatches saturate at 7.
    q0_stuck_b = 1'b1;
    go(1, 4'd3);
    wait_done(1, 1, 2000, n);
    chk("t3_len", 32'(n), 32'd785);
    chk("t3_err0_sat", 32'(err0_b), 32'd7);
    chk("t3_err1", 32'(err1_b), 32'd0);

    // Clk channel stuck high.
    clk_stuck_a = 1'b1;
    go(0, 4'd3);
    n = 1;
    while (n < 49) begin @(negedge clk); n++; end
    chk("t4_clk_err_pre", 32'(clk_err_a), 32'd0);
    @(negedge clk); n++;
    chk("t4_clk_err_first", 32'(clk_err_a), 32'd1);
    wait_done(0, n, 2000, n);
    chk("t4_len", 32'(n), 32'd785);
    chk("t4_counts", 32'({err0_a, err1_a}), 32'd0);
    clk_stuck_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_sticky", 32'(clk_err_a), 32'd1);
    go(0, 4'd3);
    chk("t4_clear", 32'(clk_err_a), 32'd0);
    wait_done(0, 1, 2000, n);
    chk("t4b_clk_err", 32'(clk_err_a), 32'd0);

    // Start and offset change mid-run are ignored.
    go(0, 4'd3);
    n = 1;
    while (n < 100) begin @(negedge clk); n++; end
    off_a = 4'd9;
    start_a = 1'b1;
    @(negedge clk); n++;
    start_a = 1'b0;
    wait_done(0, n, 2000, n);
    chk("t5_len", 32'(n), 32'd785);

    // Reset in SEL of trial 5 (offset 0: SEL ch0 spans cycles 240..247).
    viol_a = 1'b1;
    go(0, 4'd0);
    n = 1;
    while (n < 243) begin @(negedge clk); n++; end
    chk("t6_pre_err1", 32'(err1_a), 32'd5);
    chk("t6_pre_smp", 32'(smp_a), 32'h5);
    #1 rst = 1'b1;
    #1 chk("t6_rst_outs", all_a(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (800) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("t6_no_done", 32'(nd), 32'd0);
    go(0, 4'd0);
    wait_done(0, 1, 2000, n);
    chk("t6_fresh_len", 32'(n), 32'd737);
    chk("t6_fresh_err1", 32'(err1_a), 32'd16);
    viol_a = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
